// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// MEM_PARITY_EN widens each stored word with an even-parity bit.
package mem_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int AR_W      = 16;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int PTR_W     = 9;

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [1:0] CS_IDLE  = 2'b00;
  localparam logic [1:0] CS_IN    = 2'b01;
  localparam logic [1:0] CS_CHECK = 2'b10;
  localparam logic [1:0] CS_RUN   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN
  } state_t;

  function automatic state_t cs2state(input logic [1:0] cs);
    state_t s;
    s = S_IDLE;
    unique case (cs)
      CS_IN:    s = S_LOAD;
      CS_CHECK: s = S_CHECK;
      CS_RUN:   s = S_RUN;
      default:  s = S_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_array.sv
// 256-entry word store: one synchronous write port, two async reads.
// Word width includes the parity bit when MEM_PARITY_EN is set.
module mem_array
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WORD_W-1:0] rdata_b
);

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: AR, RUN access, program load and readback.
// Build with MEM_PARITY_EN to add per-byte parity and par_err.
module mem_responder
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpustate,
  input  logic              arload,
  input  logic              arinc,
  input  logic [AR_W-1:0]   bus_in,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] mem_dout,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              chk_req,
  output logic              chk_valid,
  output logic [DATA_W-1:0] chk_data,
`ifdef MEM_PARITY_EN
  output logic              par_err,
`endif
  output logic [AR_W-1:0]   ar_q
);

  state_t            state, nxt;
  logic [AR_W-1:0]   ar;
  logic [PTR_W-1:0]  ptr;
  logic              ld_fire, chk_fire;
  logic              run_rd, run_wr;
  logic              enter;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wbyte;
  logic [WORD_W-1:0] wword;
  logic [WORD_W-1:0] rd_word, ck_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = S_IDLE;
    nxt = cs2state(cpustate);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ar <= '0;
    else if (arload) ar <= bus_in;
    else if (arinc)  ar <= ar + 16'd1;
  end

  assign ar_q = ar;

  assign ld_ready = (state == S_LOAD) && !ptr[8];
  assign ld_fire  = ld_ready && ld_valid;
  assign run_rd   = (state == S_RUN) && read;
  assign run_wr   = (state == S_RUN) && write;
  assign chk_fire = (state == S_CHECK) && (nxt == S_CHECK)
                    && chk_req && !chk_valid;
  assign enter    = ((nxt == S_LOAD) && (state != S_LOAD))
                 || ((nxt == S_CHECK) && (state != S_CHECK));

  always_comb begin
    we    = 1'b0;
    waddr = ar[ADDR_W-1:0];
    wbyte = data_in;
    unique case (1'b1)
      ld_fire: begin
        we    = 1'b1;
        waddr = ptr[ADDR_W-1:0];
        wbyte = ld_data;
      end
      run_wr: begin
        we    = 1'b1;
        waddr = ar[ADDR_W-1:0];
        wbyte = data_in;
      end
      default: ;
    endcase
  end

`ifdef MEM_PARITY_EN
  assign wword = {^wbyte, wbyte};
`else
  assign wword = wbyte;
`endif

  mem_array u_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wword),
    .raddr_a (ar[ADDR_W-1:0]),
    .rdata_a (rd_word),
    .raddr_b (ptr[ADDR_W-1:0]),
    .rdata_b (ck_word)
  );

  assign mem_dout = run_rd ? rd_word[DATA_W-1:0] : '0;

`ifdef MEM_PARITY_EN
  logic chk_par;
`endif

  // A response is only launched if CHECK persists into the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      chk_valid <= 1'b0;
      chk_data  <= '0;
`ifdef MEM_PARITY_EN
      chk_par   <= 1'b0;
`endif
    end else begin
      chk_valid <= 1'b0;
      if (enter)
        ptr <= '0;
      else if (ld_fire)
        ptr <= ptr + 9'd1;
      else if (chk_fire)
        ptr <= {1'b0, ptr[7:0] + 8'd1};
      if (chk_fire) begin
        chk_valid <= 1'b1;
        chk_data  <= ck_word[DATA_W-1:0];
`ifdef MEM_PARITY_EN
        chk_par   <= ck_word[DATA_W];
`endif
      end else if (nxt != S_CHECK) begin
        chk_data  <= '0;
`ifdef MEM_PARITY_EN
        chk_par   <= 1'b0;
`endif
      end
    end
  end

`ifdef MEM_PARITY_EN
  assign par_err = (run_rd && (^rd_word))
                || (chk_valid && (^{chk_par, chk_data}));
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
// Parity checks compile only with MEM_PARITY_EN.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpustate;
  logic        arload, arinc;
  logic [15:0] bus_in;
  logic        read, write;
  logic [7:0]  data_in;
  logic [7:0]  mem_dout;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        chk_req;
  logic        chk_valid;
  logic [7:0]  chk_data;
  logic [15:0] ar_q;
`ifdef MEM_PARITY_EN
  logic        par_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder u_dut (
    .clk       (clk),
    .reset     (reset),
    .cpustate  (cpustate),
    .arload    (arload),
    .arinc     (arinc),
    .bus_in    (bus_in),
    .read      (read),
    .write     (write),
    .data_in   (data_in),
    .mem_dout  (mem_dout),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .chk_req   (chk_req),
    .chk_valid (chk_valid),
    .chk_data  (chk_data),
`ifdef MEM_PARITY_EN
    .par_err   (par_err),
`endif
    .ar_q      (ar_q)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_one(input string tag, input logic [7:0] exp);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
    check({tag, "_valid"}, 32'(chk_valid), 32'd1);
    check({tag, "_data"}, 32'(chk_data), 32'(exp));
    tick();
    check({tag, "_drop"}, 32'(chk_valid), 32'd0);
  endtask

  task automatic load_byte(input logic [7:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    cpustate = 2'b00;
    arload   = 1'b0;
    arinc    = 1'b0;
    bus_in   = '0;
    read     = 1'b0;
    write    = 1'b0;
    data_in  = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    chk_req  = 1'b0;
    #12;
    check("rst_ar", 32'(ar_q), 32'h0);
    check("rst_ldr", 32'(ld_ready), 32'd0);
    check("rst_cv", 32'(chk_valid), 32'd0);
    check("rst_cd", 32'(chk_data), 32'h0);
    check("rst_dout", 32'(mem_dout), 32'h0);
`ifdef MEM_PARITY_EN
    check("rst_par", 32'(par_err), 32'd0);
`endif
    reset = 1'b1;
    tick();

    // Load three bytes, then read them back
    cpustate = 2'b01;
    tick();
    check("ld_ready", 32'(ld_ready), 32'd1);
    load_byte(8'h11);
    load_byte(8'h22);
    load_byte(8'h33);
    cpustate = 2'b10;
    tick();
    check("ldr_in_chk", 32'(ld_ready), 32'd0);
    chk_one("chk0", 8'h11);
    chk_one("chk1", 8'h22);
    chk_one("chk2", 8'h33);

    // Held request answers once
    chk_req = 1'b1;
    tick();
    check("hold_v1", 32'(chk_valid), 32'd1);
    tick();
    check("hold_v0", 32'(chk_valid), 32'd0);
    chk_req = 1'b0;
    tick();

    // Request on the cycle CHECK is left gets dropped
    chk_req  = 1'b1;
    cpustate = 2'b00;
    tick();
    chk_req = 1'b0;
    check("drop_v", 32'(chk_valid), 32'd0);
    check("drop_d", 32'(chk_data), 32'h0);

    // RUN access
    cpustate = 2'b11;
    tick();
    bus_in = 16'h0105;
    arload = 1'b1;
    tick();
    arload = 1'b0;
    check("run_ar", 32'(ar_q), 32'h0105);
    write   = 1'b1;
    data_in = 8'hA5;
    tick();
    write = 1'b0;
    read  = 1'b1;
    #1;
    check("run_rd", 32'(mem_dout), 32'hA5);
    write   = 1'b1;
    data_in = 8'h5A;
    #1;
    check("rw_pre", 32'(mem_dout), 32'hA5);
    tick();
    write = 1'b0;
    check("rw_post", 32'(mem_dout), 32'h5A);
    bus_in = 16'h0205;
    arload = 1'b1;
    tick();
    arload = 1'b0;
    check("alias", 32'(mem_dout), 32'h5A);

    // Strobes ignored outside RUN
    read     = 1'b0;
    cpustate = 2'b00;
    tick();
    read    = 1'b1;
    write   = 1'b1;
    data_in = 8'hFF;
    #1;
    check("idle_dout", 32'(mem_dout), 32'h0);
    tick();
    write    = 1'b0;
    cpustate = 2'b11;
    tick();
    check("idle_nowr", 32'(mem_dout), 32'h5A);
    read = 1'b0;

    // AR wrap and load priority
    bus_in = 16'hFFFF;
    arload = 1'b1;
    tick();
    arload = 1'b0;
    arinc  = 1'b1;
    tick();
    arinc = 1'b0;
    check("ar_wrap", 32'(ar_q), 32'h0000);
    bus_in = 16'h0040;
    arload = 1'b1;
    arinc  = 1'b1;
    tick();
    arload = 1'b0;
    arinc  = 1'b0;
    check("ar_prio", 32'(ar_q), 32'h0040);

`ifdef MEM_PARITY_EN
    bus_in = 16'h0007;
    arload = 1'b1;
    tick();
    arload  = 1'b0;
    write   = 1'b1;
    data_in = 8'h12;
    tick();
    write = 1'b0;
    read  = 1'b1;
    #1;
    check("par_ok", 32'(par_err), 32'd0);
    u_dut.u_mem.mem[7][8] = ~u_dut.u_mem.mem[7][8];
    #1;
    check("par_bad", 32'(par_err), 32'd1);
    read = 1'b0;
    tick();
`endif

    // Full load of 257 beats
    cpustate = 2'b01;
    tick();
    for (int k = 0; k < 256; k++) begin
      if (k == 255) check("full_rdy255", 32'(ld_ready), 32'd1);
      load_byte(8'(k) ^ 8'hC3);
    end
    check("full_rdy0", 32'(ld_ready), 32'd0);
    load_byte(8'hEE);
    check("full_rdy0b", 32'(ld_ready), 32'd0);
    cpustate = 2'b10;
    tick();
    chk_one("full_m0", 8'hC3);
    chk_one("full_m1", 8'hC2);

    // Reset in the middle of a load
    cpustate = 2'b01;
    tick();
    load_byte(8'h61);
    load_byte(8'h62);
    load_byte(8'h63);
    load_byte(8'h64);
    reset = 1'b0;
    #1;
    check("mid_ldr", 32'(ld_ready), 32'd0);
    check("mid_ar", 32'(ar_q), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rdy", 32'(ld_ready), 32'd1);
    load_byte(8'h77);
    cpustate = 2'b10;
    tick();
    chk_one("mid_m0", 8'h77);
    chk_one("mid_m1", 8'h62);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, rising-edge active.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cpustate, input, 2 bits: CPU mode, where 00=IDLE, 01=IN, 10=CHECK, 11=RUN.
REQ-004 SHALL have ports arload and arinc, inputs, 1 bit each: address-register load and increment strobes from the control unit.
REQ-005 SHALL have port bus_in, input, 16 bits: internal bus value loaded into AR.
REQ-006 SHALL have ports read and write, inputs, 1 bit each: memory access strobes from the control unit.
REQ-007 SHALL have port data_in, input, 8 bits: write data driven when busmem is active.
REQ-008 SHALL have port mem_dout, output, 8 bits: read data presented to membus.
REQ-009 SHALL have ports ld_valid and ld_data[7:0], inputs, and ld_ready, output: the program-load handshake.
REQ-010 SHALL have port chk_req, input, and ports chk_valid and chk_data[7:0], outputs: the readback handshake.
REQ-011 SHALL have port ar_q, output, 16 bits: current AR value, for debug.

Function
REQ-012 SHALL keep a 16-bit AR; on arload, AR <= bus_in; else on arinc, AR <= AR+1, wrapping 0xFFFF to 0x0000; arload has priority when both are asserted; AR updates in every mode.
REQ-013 SHALL address a 256x8 memory with AR[7:0]; AR[15:8] is ignored, so address aliasing is required.
REQ-014 SHALL, in RUN with read=1, drive mem_dout = mem[AR[7:0]] combinationally in the same cycle (0-cycle latency); otherwise mem_dout = 0x00.
REQ-015 SHALL, in RUN with write=1, write data_in to mem[AR[7:0]] at the clock edge; with read and write both asserted, the write occurs and mem_dout shows the pre-write data.
REQ-016 SHALL ignore read and write outside RUN: no write occurs and mem_dout = 0.
REQ-017 SHALL implement an FSM with states IDLE, LOAD, CHECK, RUN and a 9-bit pointer ptr, following cpustate with 1-cycle registered latency, from any state to any state.
REQ-018 SHALL clear ptr to 0 on every entry into LOAD or CHECK.
REQ-019 SHALL, in LOAD, assert ld_ready while ptr < 256; each cycle with ld_valid && ld_ready writes ld_data to mem[ptr[7:0]] and increments ptr; when ptr reaches 256, ld_ready = 0 and further ld_valid is ignored until LOAD is re-entered.
REQ-020 SHALL, in CHECK, respond to chk_req when chk_valid is low by asserting chk_valid one cycle later for exactly 1 cycle, with chk_data = mem[ptr[7:0]], then increment ptr; ptr wraps at 255 to 0; a chk_req that arrives while chk_valid=1 is ignored.
REQ-021 SHALL hold ld_ready, chk_valid and chk_data at 0 outside their own state; a pending check response SHALL be dropped if the state leaves CHECK.

Reset
REQ-022 SHALL, while reset=0, asynchronously force AR=0, ptr=0, state=IDLE, chk_valid=0, chk_data=0 and ld_ready=0.
REQ-023 SHALL leave memory contents unchanged by reset.
REQ-024 SHALL, on reset assertion in the middle of a load, keep bytes already written and restart at ptr=0 on the next LOAD entry.

Configuration
REQ-025 SHALL, with MEM_PARITY_EN defined, store an even-parity bit per byte on every write and add output par_err (1 bit), which is 1 in the same cycle as a RUN read or chk_valid whose stored parity mismatches, and 0 after reset.
REQ-026 SHALL, without MEM_PARITY_EN, omit the parity storage and the par_err port.

Structure
REQ-027 SHALL place in shared package mem_pkg: the cpustate encodings (IDLE/IN/CHECK/RUN), MEM_DEPTH=256, AR_W=16, DATA_W=8, and the FSM state typedef.
REQ-028 SHALL use one sub-module, mem_array: 256 x (8 + optional parity) bits, synchronous write, asynchronous read, with one write port arbitrated by mem_responder (LOAD write or RUN write).

Verification
REQ-029 SHALL cover load then check: cpustate=01, stream 0x11,0x22,0x33 on ld_valid; cpustate=10, three chk_req -> chk_data 0x11, 0x22, 0x33, each on the cycle after its request.
REQ-030 SHALL cover RUN access: bus_in=0x0105 with arload, write=1, data_in=0xA5, then read=1 -> mem_dout=0xA5 in the same cycle, and ar_q=0x0105.
REQ-031 SHALL cover AR behaviour: AR=0xFFFF with arinc -> ar_q=0x0000; arload and arinc together with bus_in=0x0040 -> ar_q=0x0040.
REQ-032 SHALL cover a full load: 257 ld_valid beats -> ld_ready drops after beat 256, byte 257 is not written, and mem[0] still holds beat 1.
REQ-033 SHALL cover reset mid-load: reset=0 after 4 bytes -> ld_ready=0 and ar_q=0; re-enter LOAD -> next byte lands at address 0x00.
REQ-034 SHALL cover parity (with MEM_PARITY_EN): force a flipped parity bit at address 0x07, then RUN read of 0x07 -> par_err=1 in the same cycle.
